shifter_unit: RTL

Multi-cycle 8-bit shift/rotate unit that produces the shifter operand feeding the accumulator's source-select stage (the "ACC NZ SH" path). It accepts an operand, shift amount, direction and mode on a one-cycle start strobe, then shifts one bit per clock. It presents a stable result and carry with a one-cycle done pulse. The result holds until the next accepted start, so the downstream select can capture it at any later cycle.

---
 rtl/shifter_unit.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/shifter_unit.sv
// ---------------------------------------------------------------------------
// shifter_unit
//
// Multi-cycle shift/rotate unit producing the shifter operand for the
// accumulator source-select stage ("ACC NZ SH" path). An operation is
// requested with a one-cycle start strobe. The working register then moves
// one bit position per clock. The final result and carry are published
// together on entry to DONE, where they stay until the next accepted start.
//
// Optional feature macro: SHIFTER_ROTATE_EN
//    defined     : mode 10 rotates, mode 11 rotates through carry
//    not defined : modes 10/11 act as logical shifts in the requested
//                  direction, and carry_in only matters for amount 0
//
// Parameters
//    WIDTH      operand/result width
//    CNT_W      shift-amount width (max amount 2**CNT_W-1)
//
// Ports
//    clk        rising-edge clock
//    rst        synchronous active-high reset
//    start      request strobe, accepted in IDLE or DONE
//    sh_in      operand
//    sh_amt     number of bit positions to shift
//    sh_dir     0 = left, 1 = right
//    sh_mode    00 logical, 01 arithmetic, 10 rotate, 11 rotate-through-carry
//    carry_in   initial working carry (rotate-through-carry and amount 0)
//    sh_out     registered result, updated only on DONE entry or reset
//    carry_out  registered last bit shifted out
//    busy       high while shifting
//    done       one-cycle pulse when sh_out/carry_out are valid
// ---------------------------------------------------------------------------
module shifter_unit #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] sh_in,
   input  logic [CNT_W-1:0] sh_amt,
   input  logic             sh_dir,
   input  logic [1:0]       sh_mode,
   input  logic             carry_in,
   output logic [WIDTH-1:0] sh_out,
   output logic             carry_out,
   output logic             busy,
   output logic             done
);

   localparam logic [1:0] MODE_LOGIC = 2'b00;
   localparam logic [1:0] MODE_ARITH = 2'b01;
`ifdef SHIFTER_ROTATE_EN
   localparam logic [1:0] MODE_ROT   = 2'b10;
   localparam logic [1:0] MODE_RCC   = 2'b11;
`endif

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } state_t;

   state_t           state;
   state_t           state_next;

   logic [WIDTH-1:0] work_reg;
   logic [WIDTH-1:0] work_next;
   logic             work_carry;
   logic             carry_next;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_next;
   logic             dir_q;
   logic             dir_next;
   logic [1:0]       mode_q;
   logic [1:0]       mode_next;

   logic [WIDTH-1:0] step_reg;
   logic             step_carry;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // One shift step of the working register. The plain shift is formed
   // first; arithmetic and rotate modes then overwrite only the bit that
   // enters the register, so every mode shares the same out-bit selection.
   always_comb begin
      step_reg   = work_reg;
      step_carry = work_carry;
      if (!dir_q) begin
         step_carry = work_reg[WIDTH-1];
         step_reg   = {work_reg[WIDTH-2:0], 1'b0};
      end else begin
         step_carry = work_reg[0];
         step_reg   = {1'b0, work_reg[WIDTH-1:1]};
         if (mode_q == MODE_ARITH) begin
            step_reg[WIDTH-1] = work_reg[WIDTH-1];
         end
      end
`ifdef SHIFTER_ROTATE_EN
      if (mode_q == MODE_ROT) begin
         if (!dir_q) begin
            step_reg[0] = work_reg[WIDTH-1];
         end else begin
            step_reg[WIDTH-1] = work_reg[0];
         end
      end else if (mode_q == MODE_RCC) begin
         // Nine-bit rotation of {carry, reg}: the old carry re-enters.
         if (!dir_q) begin
            step_reg[0] = work_carry;
         end else begin
            step_reg[WIDTH-1] = work_carry;
         end
      end
`endif
   end

   // Next-state and next working values. Working state holds by default;
   // a start accepted in IDLE or DONE loads a fresh operation, and start
   // is deliberately ignored while SHIFT is in progress.
   always_comb begin
      state_next = state;
      work_next  = work_reg;
      carry_next = work_carry;
      cnt_next   = cnt;
      dir_next   = dir_q;
      mode_next  = mode_q;
      case (state)
         IDLE, DONE: begin
            state_next = IDLE;
            if (start) begin
               work_next  = sh_in;
               carry_next = carry_in;
               cnt_next   = sh_amt;
               dir_next   = sh_dir;
               mode_next  = sh_mode;
               state_next = (sh_amt == '0) ? DONE : SHIFT;
            end
         end
         SHIFT: begin
            work_next  = step_reg;
            carry_next = step_carry;
            cnt_next   = cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
               state_next = DONE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Working registers and published result. The result registers load
   // the final working values on the very edge that enters DONE, so the
   // downstream select never sees an intermediate shift position.
   always_ff @(posedge clk) begin
      if (rst) begin
         work_reg   <= '0;
         work_carry <= 1'b0;
         cnt        <= '0;
         dir_q      <= 1'b0;
         mode_q     <= MODE_LOGIC;
         sh_out     <= '0;
         carry_out  <= 1'b0;
      end else begin
         work_reg   <= work_next;
         work_carry <= carry_next;
         cnt        <= cnt_next;
         dir_q      <= dir_next;
         mode_q     <= mode_next;
         if (state_next == DONE) begin
            sh_out    <= work_next;
            carry_out <= carry_next;
         end
      end
   end

   // Status flags decode the state register only, so they carry no
   // combinational path from the inputs.
   always_comb begin
      busy = (state == SHIFT);
      done = (state == DONE);
   end

endmodule
